// File: rtl/display_pkg.sv
// display_pkg: shared types and constants for scanned multi-digit displays.
//   scan_state_e : scan FSM state (DEAD = all enables off, DRIVE = one digit lit)
//   nibble_t     : one BCD/hex digit value
//   MAX_DIGITS   : largest digit count supported by the scan controller
package display_pkg;

    typedef enum logic {
        DEAD  = 1'b0,
        DRIVE = 1'b1
    } scan_state_e;

    typedef logic [3:0] nibble_t;

    localparam int MAX_DIGITS = 8;

endpackage

// File: rtl/scan_slot_timer.sv
// scan_slot_timer: per-slot cycle counter for time-multiplexed displays.
// Counts DEAD_CYCLES while in the dead phase and SLOT_CYCLES-DEAD_CYCLES
// while in the drive phase, pulsing the matching *_done on the last cycle.
// Ports:
//   clk, rst_n   : clock, asynchronous active-low reset
//   sync         : force the counter back to 0 (slot restart)
//   in_drive     : 1 while the owner FSM is in its drive phase
//   dead_done    : last cycle of the dead phase
//   slot_done    : last cycle of the drive phase (end of slot)
module scan_slot_timer #(
    parameter int SLOT_CYCLES = 1000,
    parameter int DEAD_CYCLES = 16
) (
    input  logic clk,
    input  logic rst_n,
    input  logic sync,
    input  logic in_drive,
    output logic dead_done,
    output logic slot_done
);

    localparam int CW = (SLOT_CYCLES > 2) ? $clog2(SLOT_CYCLES) : 1;
    localparam logic [CW-1:0] DEAD_LAST  = CW'(DEAD_CYCLES - 1);
    localparam logic [CW-1:0] DRIVE_LAST = CW'(SLOT_CYCLES - DEAD_CYCLES - 1);

    logic [CW-1:0] cnt_q, cnt_d;

    always_comb begin
        dead_done = !in_drive && (cnt_q == DEAD_LAST);
        slot_done = in_drive && (cnt_q == DRIVE_LAST);
        cnt_d     = cnt_q + CW'(1);
        if (sync || dead_done || slot_done) cnt_d = '0;
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) cnt_q <= '0;
        else        cnt_q <= cnt_d;
    end

endmodule

// File: rtl/bcd_scan_ctrl.sv
// bcd_scan_ctrl: scans NUM_DIGITS digits through one shared 7-segment decoder.
// Writes land in a shadow file; a commit copies shadow to active only at the
// frame boundary (entry to slot 0), so multi-digit updates never tear.
// Optional macro BCD_SCAN_LZB_EN enables leading-zero blanking.
// Ports:
//   clk, rst_n      : clock, asynchronous active-low reset
//   wr_en/addr/data : shadow write (out-of-range addresses ignored)
//   wr_commit       : request shadow->active copy at next frame boundary
//   blank           : force all enables low (scan keeps running)
//   digit_bcd       : nibble for the external decoder, stable per slot
//   digit_en        : one-hot digit enable
//   frame_start     : one-cycle pulse when slot 0 begins
//   commit_pending  : a commit is waiting for the frame boundary
module bcd_scan_ctrl
    import display_pkg::*;
#(
    parameter int NUM_DIGITS  = 4,
    parameter int SLOT_CYCLES = 1000,
    parameter int DEAD_CYCLES = 16
) (
    input  logic                          clk,
    input  logic                          rst_n,
    input  logic                          wr_en,
    input  logic [$clog2(NUM_DIGITS)-1:0] wr_addr,
    input  logic [3:0]                    wr_data,
    input  logic                          wr_commit,
    input  logic                          blank,
    output logic [3:0]                    digit_bcd,
    output logic [NUM_DIGITS-1:0]         digit_en,
    output logic                          frame_start,
    output logic                          commit_pending
);

    localparam int IW = $clog2(NUM_DIGITS);
    localparam logic [IW-1:0] IDX_LAST = IW'(NUM_DIGITS - 1);
    localparam logic [IW:0]   ADDR_LIM = (IW + 1)'(NUM_DIGITS);

    scan_state_e state_q, state_d;
    logic [IW-1:0] idx_q, idx_d;
    logic started_q, started_d;
    nibble_t [NUM_DIGITS-1:0] shadow_q, shadow_d, active_q, active_d;
    logic pend_q, pend_d;
    nibble_t bcd_q, bcd_d;
    logic [NUM_DIGITS-1:0] en_q, en_d;
    logic fs_q, fs_d;
    logic enter_dead, boundary, dead_done, slot_done, hide;

`ifdef BCD_SCAN_LZB_EN
    logic zero_run;
`endif

    // The first edge after reset is treated as the entry into slot 0, so the
    // timer is held at 0 for that edge and the first frame_start fires there.
    scan_slot_timer #(
        .SLOT_CYCLES(SLOT_CYCLES),
        .DEAD_CYCLES(DEAD_CYCLES)
    ) u_timer (
        .clk      (clk),
        .rst_n    (rst_n),
        .sync     (!started_q),
        .in_drive (state_q == DRIVE),
        .dead_done(dead_done),
        .slot_done(slot_done)
    );

    always_comb begin
        state_d    = state_q;
        idx_d      = idx_q;
        enter_dead = 1'b0;
        started_d  = 1'b1;
        if (!started_q) begin
            state_d    = DEAD;
            idx_d      = '0;
            enter_dead = 1'b1;
        end else if (state_q == DEAD && dead_done) begin
            state_d = DRIVE;
        end else if (state_q == DRIVE && slot_done) begin
            state_d    = DEAD;
            idx_d      = (idx_q == IDX_LAST) ? '0 : idx_q + IW'(1);
            enter_dead = 1'b1;
        end
        boundary = enter_dead && (idx_d == '0);

        shadow_d = shadow_q;
        if (wr_en && ({1'b0, wr_addr} < ADDR_LIM)) shadow_d[wr_addr] = wr_data;

        // Copy from shadow next-state so a same-cycle write is included.
        active_d = active_q;
        pend_d   = pend_q;
        if (boundary) begin
            if (pend_q || wr_commit) active_d = shadow_d;
            pend_d = 1'b0;
        end else if (wr_commit) begin
            pend_d = 1'b1;
        end

        bcd_d = enter_dead ? active_d[idx_d] : bcd_q;

        hide = 1'b0;
`ifdef BCD_SCAN_LZB_EN
        // Digit i>0 is hidden when it and every higher digit are zero.
        zero_run = 1'b1;
        for (int i = NUM_DIGITS - 1; i >= 1; i--) begin
            zero_run = zero_run && (active_d[i] == 4'd0);
            if (idx_d == IW'(i)) hide = zero_run;
        end
`endif

        en_d = '0;
        if (state_d == DRIVE && !blank && !hide) en_d[idx_d] = 1'b1;

        fs_d = boundary;
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q   <= DEAD;
            idx_q     <= '0;
            started_q <= 1'b0;
            shadow_q  <= '0;
            active_q  <= '0;
            pend_q    <= 1'b0;
            bcd_q     <= '0;
            en_q      <= '0;
            fs_q      <= 1'b0;
        end else begin
            state_q   <= state_d;
            idx_q     <= idx_d;
            started_q <= started_d;
            shadow_q  <= shadow_d;
            active_q  <= active_d;
            pend_q    <= pend_d;
            bcd_q     <= bcd_d;
            en_q      <= en_d;
            fs_q      <= fs_d;
        end
    end

    assign digit_bcd      = bcd_q;
    assign digit_en       = en_q;
    assign frame_start    = fs_q;
    assign commit_pending = pend_q;

endmodule

// File: tb/tb_bcd_scan_ctrl.sv
module tb_bcd_scan_ctrl;

    localparam int N     = 4;
    localparam int SLOT  = 8;
    localparam int DEAD  = 2;
    localparam int FRAME = N * SLOT;
`ifdef BCD_SCAN_LZB_EN
    localparam bit LZB = 1'b1;
`else
    localparam bit LZB = 1'b0;
`endif

    logic clk = 1'b0;
    logic rst_n = 1'b0;
    logic wr_en = 1'b0, wr_commit = 1'b0, blank = 1'b0;
    logic [1:0] wr_addr = '0;
    logic [3:0] wr_data = '0;
    logic [3:0] digit_bcd;
    logic [N-1:0] digit_en;
    logic frame_start, commit_pending;

    bcd_scan_ctrl #(.NUM_DIGITS(N), .SLOT_CYCLES(SLOT), .DEAD_CYCLES(DEAD)) dut (
        .clk(clk), .rst_n(rst_n), .wr_en(wr_en), .wr_addr(wr_addr),
        .wr_data(wr_data), .wr_commit(wr_commit), .blank(blank),
        .digit_bcd(digit_bcd), .digit_en(digit_en),
        .frame_start(frame_start), .commit_pending(commit_pending)
    );

    always #5 clk = ~clk;

    typedef struct {
        logic [N-1:0] en;
        logic         fs;
        logic [3:0]   bcd;
        logic         pend;
    } exp_t;

    typedef struct {
        logic [1:0] addr;
        logic [3:0] data;
        logic [3:0] exp_bcd;
    } wr_vec_t;

    exp_t       sbq[$];
    logic [3:0] bcd_sb[$];
    int         fs_list[$];
    int n_cmp = 0, n_fail = 0;
    int cyc = 0, last_fs = 0, prev_fs = 0;
    logic [3:0] m_sh[N], m_act[N];
    bit m_pend = 1'b0;
    logic [N-1:0] en_seen = '0;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s @cyc %0d: got %0h expected %0h", name, cyc, act, exp);
        end
    endtask

    function automatic bit hidden(input int s);
        bit h;
        h = LZB && (s > 0);
        for (int j = s; j < N; j++) if (m_act[j] != 4'd0) h = 1'b0;
        return h;
    endfunction

    task automatic model_reset();
        cyc = 0;
        m_pend = 1'b0;
        for (int i = 0; i < N; i++) begin
            m_sh[i] = '0;
            m_act[i] = '0;
        end
        fs_list.delete();
    endtask

    // One clock: update the cycle model from the inputs sampled at the edge,
    // queue the expectation, then compare on the falling edge.
    task automatic tick();
        exp_t e;
        int pos, s;
        @(posedge clk);
        cyc++;
        pos = (cyc - 1) % FRAME;
        s   = pos / SLOT;
        if (wr_en) m_sh[wr_addr] = wr_data;
        if (pos == 0) begin
            if (m_pend || wr_commit) m_act = m_sh;
            m_pend = 1'b0;
        end else if (wr_commit) begin
            m_pend = 1'b1;
        end
        e.fs   = (pos == 0);
        e.en   = ((pos % SLOT) >= DEAD && !blank && !hidden(s)) ? N'(1 << s) : '0;
        e.bcd  = m_act[s];
        e.pend = m_pend;
        sbq.push_back(e);
        @(negedge clk);
        e = sbq.pop_front();
        chk("digit_en", 32'(digit_en), 32'(e.en));
        chk("frame_start", 32'(frame_start), 32'(e.fs));
        chk("digit_bcd", 32'(digit_bcd), 32'(e.bcd));
        chk("commit_pending", 32'(commit_pending), 32'(e.pend));
        en_seen |= digit_en;
        if (frame_start) begin
            fs_list.push_back(cyc);
            prev_fs = last_fs;
            last_fs = cyc;
        end
    endtask

    task automatic wait_fs();
        int k = 0;
        do begin
            tick();
            k++;
        end while (frame_start !== 1'b1 && k < 2 * FRAME);
        chk("wait_frame_start", 32'(frame_start), 32'd1);
    endtask

    task automatic write(input logic [1:0] a, input logic [3:0] d);
        wr_en = 1'b1; wr_addr = a; wr_data = d;
        tick();
        wr_en = 1'b0;
    endtask

    wr_vec_t vec_a[4];
    wr_vec_t vec_b[4];

    initial begin
        vec_a = '{'{2'd0, 4'd1, 4'd1}, '{2'd1, 4'd2, 4'd2},
                  '{2'd2, 4'd3, 4'd3}, '{2'd3, 4'd4, 4'd4}};
        vec_b = '{'{2'd3, 4'd0, 4'd0}, '{2'd2, 4'd0, 4'd0},
                  '{2'd1, 4'd5, 4'd5}, '{2'd0, 4'd0, 4'd0}};
        model_reset();

        // Reset state
        #12;
        chk("rst_digit_en", 32'(digit_en), 32'd0);
        chk("rst_digit_bcd", 32'(digit_bcd), 32'd0);
        chk("rst_frame_start", 32'(frame_start), 32'd0);
        chk("rst_commit_pending", 32'(commit_pending), 32'd0);

        // Scan order and frame_start placement
        @(negedge clk);
        rst_n = 1'b1;
        repeat (40) tick();
        chk("fs_count", 32'(fs_list.size()), 32'd2);
        chk("fs_first", 32'(fs_list[0]), 32'd1);
        chk("fs_second", 32'(fs_list[1]), 32'd33);

        // Tear-free commit issued mid-frame
        for (int i = 0; i < 4; i++) write(vec_a[i].addr, vec_a[i].data);
        wr_commit = 1'b1;
        for (int i = 0; i < 4; i++) bcd_sb.push_back(vec_a[i].exp_bcd);
        tick();
        wr_commit = 1'b0;
        chk("pend_after_commit", 32'(commit_pending), 32'd1);
        chk("bcd_before_boundary", 32'(digit_bcd), 32'd0);
        wait_fs();
        for (int s = 0; s < 4; s++) begin
            if (s > 0) repeat (SLOT) tick();
            chk("commit_slot_bcd", 32'(digit_bcd), 32'(bcd_sb.pop_front()));
        end

        // Write + commit on the boundary cycle itself
        while (cyc % FRAME != 0) tick();
        wr_en = 1'b1; wr_addr = 2'd2; wr_data = 4'd9; wr_commit = 1'b1;
        tick();
        wr_en = 1'b0; wr_commit = 1'b0;
        chk("boundary_fs", 32'(frame_start), 32'd1);
        chk("boundary_no_pend", 32'(commit_pending), 32'd0);
        repeat (2 * SLOT) tick();
        chk("boundary_slot2_bcd", 32'(digit_bcd), 32'd9);

        // Blank for 10 cycles in the middle of a frame
        blank = 1'b1;
        en_seen = '0;
        repeat (10) tick();
        blank = 1'b0;
        chk("blank_en_seen", 32'(en_seen), 32'd0);
        wait_fs();
        chk("blank_fs_spacing", 32'(last_fs - prev_fs), 32'(FRAME));

        // Leading-zero blanking: active = {0,0,5,0}
        for (int i = 0; i < 4; i++) write(vec_b[i].addr, vec_b[i].data);
        wr_commit = 1'b1;
        tick();
        wr_commit = 1'b0;
        wait_fs();
        en_seen = '0;
        repeat (FRAME) tick();
        chk("lzb_en_seen", 32'(en_seen), LZB ? 32'h3 : 32'hF);

        // Asynchronous reset in the middle of slot 2 drive
        write(2'd2, 4'd7);
        wr_commit = 1'b1;
        tick();
        wr_commit = 1'b0;
        wait_fs();
        repeat (2 * SLOT + 3) tick();
        chk("pre_rst_en", 32'(digit_en), 32'h4);
        chk("pre_rst_bcd", 32'(digit_bcd), 32'd7);
        wr_commit = 1'b1;
        tick();
        wr_commit = 1'b0;
        chk("pre_rst_pend", 32'(commit_pending), 32'd1);
        #2 rst_n = 1'b0;
        #1;
        chk("async_rst_en", 32'(digit_en), 32'd0);
        chk("async_rst_bcd", 32'(digit_bcd), 32'd0);
        chk("async_rst_pend", 32'(commit_pending), 32'd0);
        model_reset();
        @(negedge clk);
        rst_n = 1'b1;
        repeat (12) tick();
        chk("restart_fs_first", 32'(fs_list[0]), 32'd1);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
        $finish;
    end

endmodule
